// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract: one SEG-bit slice per stage, carry registered between stages.
// Optional signed saturation of the result when PIPELINED_RIPPLE_ADDER_SAT_EN is defined.
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int STAGES = WIDTH / SEG;
    localparam int L      = STAGES - 1;
    localparam int NSK    = (STAGES > 1) ? STAGES - 1 : 1;

    generate
        if (WIDTH % SEG != 0) begin : g_width_chk
            $error("pipelined_ripple_adder: WIDTH must be a multiple of SEG");
        end
    endgenerate

    // Skew registers between stages; the last stage lands in the output registers.
    logic [NSK-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [NSK-1:0]            c_q, v_q;
    logic [WIDTH-1:0]          sum_q;
    logic                      cout_q, ovf_q, ovld_q;

    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_d;
    logic [STAGES-1:0]            c_in, v_in, c_d;
    logic [SEG:0]                 slice;
    logic                         ovf_d;
    logic                         adv;

    assign adv      = !ovld_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        a_in    = '0;
        b_in    = '0;
        s_in    = '0;
        c_in    = '0;
        v_in    = '0;
        a_in[0] = A;
        b_in[0] = Sub ? ~B : B;
        c_in[0] = Sub ? 1'b1 : Cin;
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    always_comb begin
        s_d   = '0;
        c_d   = '0;
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                  + {{SEG{1'b0}}, c_in[k]};
            s_d[k]                = s_in[k];
            s_d[k][k*SEG +: SEG]  = slice[SEG-1:0];
            c_d[k]                = slice[SEG];
        end
        ovf_d = (a_in[L][WIDTH-1] == b_in[L][WIDTH-1]) && (s_d[L][WIDTH-1] != a_in[L][WIDTH-1]);
`ifdef PIPELINED_RIPPLE_ADDER_SAT_EN
        if (ovf_d)
            s_d[L] = a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    // The whole pipe moves as one; a stalled output freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= '0;
            v_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            ovld_q <= 1'b0;
        end else if (adv) begin
            a_q    <= a_in[NSK-1:0];
            b_q    <= b_in[NSK-1:0];
            s_q    <= s_d[NSK-1:0];
            c_q    <= c_d[NSK-1:0];
            v_q    <= v_in[NSK-1:0];
            ovld_q <= v_in[L];
            if (v_in[L]) begin
                sum_q  <= s_d[L];
                cout_q <= c_d[L];
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = ovld_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder: integer reference model, latency and stall checks.
module tb_pipelined_ripple_adder;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0, B = '0;
    logic             Cin = 1'b0, Sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] Sum;
    logic             Cout, Ovf;

    pipelined_ripple_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               cyc;
        int               stl;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, stalls = 0;
    logic rand_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Plain integer arithmetic: sub is a - b, add is a + b + cin, overflow is range escape.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t r;
        int u, s, sa, sb_;
        sa = $signed(a);
        sb_ = $signed(b);
        if (sub) begin
            u = int'(a) + (1 << WIDTH) - int'(b);
            s = sa - sb_;
        end else begin
            u = int'(a) + int'(b) + int'(cin);
            s = sa + sb_ + int'(cin);
        end
        r.sum  = u[WIDTH-1:0];
        r.cout = u[WIDTH];
        r.ovf  = (s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1)));
`ifdef PIPELINED_RIPPLE_ADDER_SAT_EN
        if (r.ovf) r.sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        r.cyc = 0;
        r.stl = 0;
        return r;
    endfunction

    // Monitor: accepts, output transfers, stall behaviour, all sampled mid-cycle.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout, held_ovf;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", 32'(out_valid), 32'd1);
                chk("stall_sum_held", 32'(Sum), 32'(held_sum));
                chk("stall_flags_held", {30'd0, Cout, Ovf}, {30'd0, held_cout, held_ovf});
            end
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sum", 32'(Sum), 32'(e.sum));
                    chk("cout", 32'(Cout), 32'(e.cout));
                    chk("ovf", 32'(Ovf), 32'(e.ovf));
                    chk("latency", 32'(cyc), 32'(e.cyc + STAGES + (stalls - e.stl)));
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                stalls++;
                held_sum  = Sum;
                held_cout = Cout;
                held_ovf  = Ovf;
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(A, B, Cin, Sub);
                e.cyc = cyc;
                e.stl = stalls;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        int waited;
        A = a; B = b; Cin = cin; Sub = sub;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $fatal(1, "input never accepted");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_cout_ovf", {30'd0, Cout, Ovf}, 32'd0);
        @(posedge clk);
        #1;

        // Directed boundary cases.
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0000, 16'h0001, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0000, 16'h8000, 1'b0, 1'b1);
        drain();

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 8; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
        drain();

        // Same stream with a 3-cycle output stall mid-run.
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b0, 1'b0);
        send(16'h5555, 16'h6666, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(16'hABCD, 16'h1234, 1'b1, 1'b0);
        drain();

        // Random traffic with random backpressure.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                end
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
